// File: rtl/piece_move_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : piece_move_scheduler
// Purpose  : Serialises left/right/down/gravity moves of the falling piece
//            through the shared collision checker; owns the live position.
// Options  : GRAVITY_TIMER_EN - internal gravity counter replaces gravityTick
// Revision : 1.0 - initial release
// ============================================================================
module piece_move_scheduler #(
  parameter int SPAWN_X        = 6,
  parameter int Y_MAX          = 16,
  parameter int X_MAX          = 12,
  parameter int GRAVITY_PERIOD = 50000000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       spawn,
  input  logic [1:0] nextBlock,
  input  logic       reqLeft,
  input  logic       reqRight,
  input  logic       reqDown,
  input  logic       gravityTick,
  input  logic       canMove,
  output logic       chkEnable,
  output logic [1:0] chkDir,
  output logic [1:0] chkBlock,
  output logic [3:0] chkX,
  output logic [4:0] chkY,
  output logic [3:0] XPOS,
  output logic [4:0] YPOS,
  output logic [1:0] currentBlock,
  output logic       pieceActive,
  output logic       moved,
  output logic       lockPiece
);

  typedef enum logic [1:0] {
    S_NOPIECE = 2'd0,
    S_IDLE    = 2'd1,
    S_CHECK   = 2'd2,
    S_EVAL    = 2'd3
  } state_t;

  // Direction codes double as the pending-bit index.
  localparam logic [1:0] c_dir_left  = 2'b00;
  localparam logic [1:0] c_dir_right = 2'b01;
  localparam logic [1:0] c_dir_down  = 2'b10;
  localparam int         c_idx_left  = 0;
  localparam int         c_idx_right = 1;
  localparam int         c_idx_down  = 2;

  localparam logic [3:0] c_spawn_x = 4'(SPAWN_X);
  localparam logic [3:0] c_x_max   = 4'(X_MAX);
  localparam logic [4:0] c_y_max   = 5'(Y_MAX);

  state_t     r_state, w_state_n;
  logic [2:0] r_pend, w_pend_n, w_pend_set, w_sel_mask;
  logic [1:0] r_sel, w_sel_n;
  logic [3:0] r_xpos, w_xpos_n;
  logic [4:0] r_ypos, w_ypos_n;
  logic [1:0] r_block, w_block_n;
  logic       r_active, w_active_n;
  logic       r_moved, w_moved_n;
  logic       r_lock, w_lock_n;
  logic       w_gravity;

`ifdef GRAVITY_TIMER_EN
  localparam int c_cnt_w = (GRAVITY_PERIOD > 1) ? $clog2(GRAVITY_PERIOD) : 1;

  logic [c_cnt_w-1:0] r_grav_cnt;
  logic               w_grav_wrap;

  assign w_grav_wrap = r_active && (r_grav_cnt == c_cnt_w'(GRAVITY_PERIOD - 1));
  assign w_gravity   = w_grav_wrap;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_grav_cnt <= '0;
    end else if (spawn || w_grav_wrap) begin
      r_grav_cnt <= '0;
    end else if (r_active) begin
      r_grav_cnt <= r_grav_cnt + c_cnt_w'(1);
    end
  end
`else
  assign w_gravity = gravityTick;
`endif

  assign w_sel_mask = 3'b001 << r_sel;

  always_comb begin
    w_state_n  = r_state;
    w_pend_n   = r_pend;
    w_sel_n    = r_sel;
    w_xpos_n   = r_xpos;
    w_ypos_n   = r_ypos;
    w_block_n  = r_block;
    w_active_n = r_active;
    w_moved_n  = 1'b0;
    w_lock_n   = 1'b0;
    // Opposing left/right in one cycle cancel each other.
    w_pend_set = {w_gravity | reqDown, reqRight & ~reqLeft, reqLeft & ~reqRight};

    case (r_state)
      S_NOPIECE: begin
        w_pend_n   = '0;
        w_pend_set = '0;
      end

      S_IDLE: begin
        if (r_pend[c_idx_down]) begin
          if (r_ypos == c_y_max) begin
            w_lock_n   = 1'b1;
            w_active_n = 1'b0;
            w_pend_n   = '0;
            w_pend_set = '0;
            w_state_n  = S_NOPIECE;
          end else begin
            w_sel_n   = c_dir_down;
            w_state_n = S_CHECK;
          end
        end else if (r_pend[c_idx_left]) begin
          if (r_xpos == 4'd0) begin
            w_pend_n[c_idx_left] = 1'b0;
          end else begin
            w_sel_n   = c_dir_left;
            w_state_n = S_CHECK;
          end
        end else if (r_pend[c_idx_right]) begin
          if (r_xpos == c_x_max) begin
            w_pend_n[c_idx_right] = 1'b0;
          end else begin
            w_sel_n   = c_dir_right;
            w_state_n = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        w_pend_n  = r_pend & ~w_sel_mask;
        w_state_n = S_EVAL;
      end

      S_EVAL: begin
        w_state_n = S_IDLE;
        if (canMove) begin
          w_moved_n = 1'b1;
          case (r_sel)
            c_dir_left:  w_xpos_n = r_xpos - 4'd1;
            c_dir_right: w_xpos_n = r_xpos + 4'd1;
            default:     w_ypos_n = r_ypos + 5'd1;
          endcase
        end else if (r_sel == c_dir_down) begin
          w_lock_n   = 1'b1;
          w_active_n = 1'b0;
          w_pend_n   = '0;
          w_pend_set = '0;
          w_state_n  = S_NOPIECE;
        end
      end

      default: w_state_n = S_NOPIECE;
    endcase

    w_pend_n = w_pend_n | w_pend_set;

    // Spawn wins over everything, including an in-flight check.
    if (spawn) begin
      w_state_n  = S_IDLE;
      w_xpos_n   = c_spawn_x;
      w_ypos_n   = 5'd0;
      w_block_n  = nextBlock;
      w_active_n = 1'b1;
      w_pend_n   = '0;
      w_moved_n  = 1'b0;
      w_lock_n   = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= S_NOPIECE;
      r_pend   <= '0;
      r_sel    <= c_dir_left;
      r_xpos   <= c_spawn_x;
      r_ypos   <= 5'd0;
      r_block  <= 2'd0;
      r_active <= 1'b0;
      r_moved  <= 1'b0;
      r_lock   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_pend   <= w_pend_n;
      r_sel    <= w_sel_n;
      r_xpos   <= w_xpos_n;
      r_ypos   <= w_ypos_n;
      r_block  <= w_block_n;
      r_active <= w_active_n;
      r_moved  <= w_moved_n;
      r_lock   <= w_lock_n;
    end
  end

  assign chkEnable    = (r_state == S_CHECK);
  assign chkDir       = chkEnable ? r_sel : 2'b00;
  assign chkBlock     = r_block;
  assign chkX         = r_xpos;
  assign chkY         = r_ypos;
  assign XPOS         = r_xpos;
  assign YPOS         = r_ypos;
  assign currentBlock = r_block;
  assign pieceActive  = r_active;
  assign moved        = r_moved;
  assign lockPiece    = r_lock;

endmodule
`default_nettype wire
